// File: rtl/fp_divider.sv
// fp_divider: sequential FP32 divider (data1 / data2) using 25-step restoring
// division of the 24-bit significands. Simplified number model: hidden bit is
// always 1, no denormals, truncation instead of rounding, exponent wraps
// silently. Fixed latency for every operand, zero operands included.
module fp_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output logic        dz
);

  localparam int unsigned SIG_W  = 24;
  localparam int unsigned QUO_W  = SIG_W + 1;
  localparam int unsigned LAST_IT = QUO_W - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [31:0]        opa;
  logic [31:0]        opb;
  logic [QUO_W-1:0]   rem;
  logic [SIG_W-1:0]   div;
  logic [QUO_W-1:0]   q;
  logic [4:0]         cnt;

  logic               q_bit_c;
  logic [QUO_W-1:0]   rem_sub_c;
  logic [7:0]         expo_c;
  logic [22:0]        mant_c;
  logic               sign_c;
  logic               a_zero_c;
  logic               b_zero_c;
  logic [31:0]        quot_c;

  // One restoring-division step: subtract divisor when it fits.
  always_comb begin
    q_bit_c   = (rem >= {1'b0, div});
    rem_sub_c = q_bit_c ? (rem - {1'b0, div}) : rem;
  end

  // Normalise the quotient and resolve zero operands. The exponent is taken
  // modulo 256, which is the low byte of the wider sum.
  always_comb begin
    sign_c   = opa[31] ^ opb[31];
    a_zero_c = (opa == 32'h0000_0000);
    b_zero_c = (opb == 32'h0000_0000);
    if (q[QUO_W-1]) begin
      mant_c = q[23:1];
      expo_c = opa[30:23] - opb[30:23] + 8'd127;
    end else begin
      mant_c = q[22:0];
      expo_c = opa[30:23] - opb[30:23] + 8'd126;
    end
    if (b_zero_c && a_zero_c) begin
      quot_c = 32'h7FC0_0000;
    end else if (b_zero_c) begin
      quot_c = {sign_c, 8'hFF, 23'd0};
    end else if (a_zero_c) begin
      quot_c = 32'h0000_0000;
    end else begin
      quot_c = {sign_c, expo_c, mant_c};
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      opa    <= 32'd0;
      opb    <= 32'd0;
      rem    <= '0;
      div    <= '0;
      q      <= '0;
      cnt    <= 5'd0;
      result <= 32'd0;
      done   <= 1'b0;
      busy   <= 1'b0;
      dz     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            opa   <= data1;
            opb   <= data2;
            rem   <= {2'b01, data1[22:0]};
            div   <= {1'b1, data2[22:0]};
            q     <= '0;
            cnt   <= 5'd0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          q   <= {q[QUO_W-2:0], q_bit_c};
          rem <= rem_sub_c << 1;
          cnt <= cnt + 5'd1;
          if (cnt == 5'(LAST_IT)) begin
            state <= DONE;
          end
        end
        DONE: begin
          result <= quot_c;
          dz     <= b_zero_c;
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divider.sv
// tb_fp_divider: vector table, randomized reference-model checks and
// hand-written handshake/reset sequences for fp_divider.
module tb_fp_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic        dz;

  int checks = 0;
  int errors = 0;

  localparam int LATENCY = 26;

  fp_divider dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .data1  (data1),
    .data2  (data2),
    .result (result),
    .done   (done),
    .busy   (busy),
    .dz     (dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_r;
    logic        exp_dz;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact integer quotient of the significands scaled by 2^24.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
    longint unsigned n1, n2, qq, mant;
    int e;
    logic sgn;
    sgn = a[31] ^ b[31];
    if (a == 0 && b == 0) return {1'b1, 32'h7FC0_0000};
    if (b == 0) return {1'b1, sgn, 8'hFF, 23'd0};
    if (a == 0) return 33'd0;
    n1 = 64'h80_0000 + longint'(a[22:0]);
    n2 = 64'h80_0000 + longint'(b[22:0]);
    qq = (n1 << 24) / n2;
    e  = int'(a[30:23]) - int'(b[30:23]);
    if (qq >= 64'h100_0000) begin
      e    = e + 127;
      mant = (qq >> 1) & 64'h7F_FFFF;
    end else begin
      e    = e + 126;
      mant = qq & 64'h7F_FFFF;
    end
    return {1'b0, sgn, 8'(e & 255), 23'(mant)};
  endfunction

  // Issue one division from idle and wait (bounded) for its done pulse.
  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     output logic [31:0] r, output logic z, output int lat);
    @(negedge clk);
    data1 = a;
    data2 = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    r = result;
    z = dz;
    chk("done_seen", 32'(done), 32'd1);
    chk("busy_in_done_cycle", 32'(busy), 32'd1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_low_after", 32'(busy), 32'd0);
  endtask

  vec_t        vecs[$];
  logic [31:0] r;
  logic        z;
  logic [32:0] m;
  int          lat;
  int          n;
  int          first_done;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    data1 = 32'd0;
    data2 = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_result", result, 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_dz", 32'(dz), 32'd0);
    rst = 1'b0;

    vecs.push_back('{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0});
    vecs.push_back('{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0});
    vecs.push_back('{32'hBFC0_0000, 32'h3F00_0000, 32'hC040_0000, 1'b0});
    vecs.push_back('{32'h3F00_0000, 32'hBFC0_0000, 32'hBEAA_AAAA, 1'b0});
    vecs.push_back('{32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0});
    vecs.push_back('{32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1'b1});
    vecs.push_back('{32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b1});
    vecs.push_back('{32'h4120_0000, 32'h40A0_0000, 32'h4000_0000, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 1'b0});

    foreach (vecs[i]) begin
      run(vecs[i].a, vecs[i].b, r, z, lat);
      chk($sformatf("vec%0d_result", i), r, vecs[i].exp_r);
      chk($sformatf("vec%0d_dz", i), 32'(z), 32'(vecs[i].exp_dz));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(LATENCY));
    end

    // Randomized operands, occasionally zero.
    for (int i = 0; i < 120; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 15) == 0) a = 32'd0;
      if ($urandom_range(0, 15) == 0) b = 32'd0;
      m = model(a, b);
      run(a, b, r, z, lat);
      chk($sformatf("rand%0d_result a=%h b=%h", i, a, b), r, m[31:0]);
      chk($sformatf("rand%0d_dz", i), 32'(z), 32'(m[32]));
    end

    // Operand changes and extra start pulses during CALC are ignored.
    @(negedge clk);
    data1 = 32'h40C0_0000;
    data2 = 32'h4000_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    data1 = 32'h3F80_0000;
    data2 = 32'h4040_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("ignore_done_seen", 32'(done), 32'd1);
    chk("ignore_result", result, 32'h4040_0000);
    chk("ignore_latency", 32'(n + 6), 32'(LATENCY));
    @(negedge clk);

    // Reset at CALC iteration 10 aborts with no done.
    data1 = 32'h3F80_0000;
    data2 = 32'h4040_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_result", result, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_dz", 32'(dz), 32'd0);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("abort_no_done", 32'(n), 32'd0);
    run(32'hBF80_0000, 32'h0000_0000, r, z, lat);
    chk("post_abort_result", r, 32'hFF80_0000);
    chk("post_abort_dz", 32'(z), 32'd1);
    chk("post_abort_latency", 32'(lat), 32'(LATENCY));

    // Back-to-back with start held high.
    @(negedge clk);
    data1 = 32'h4120_0000;
    data2 = 32'h40A0_0000;
    start = 1'b1;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_done", 32'(done), 32'd1);
    chk("b2b_first_result", result, 32'h4000_0000);
    @(negedge clk);
    chk("b2b_reaccept_busy", 32'(busy), 32'd1);
    chk("b2b_reaccept_done_low", 32'(done), 32'd0);
    first_done = 1;
    while (!done && first_done < 60) begin
      @(negedge clk);
      first_done++;
    end
    start = 1'b0;
    chk("b2b_second_done", 32'(done), 32'd1);
    chk("b2b_period", 32'(first_done), 32'd27);
    chk("b2b_second_result", result, 32'h4000_0000);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
